// File: rtl/dut_op_responder_if.sv
// Handshake bundle between the prewrapper initiator and the op/scan responder.
// master = initiator side, slave = responder side.
interface dut_op_responder_if #(
  parameter int unsigned DATA_W = 32
) ();
  logic [DATA_W-1:0] data_in;
  logic [DATA_W-1:0] data_out;
  logic              dut_val_op;
  logic              dut_op_ack;
  logic              dut_op_commit;
  logic              dut_commit_ack;
  logic [DATA_W-1:0] dft_out;
  logic              dft_val_op;
  logic              dft_op_ack;
  logic              dft_op_commit;
  logic              dft_output_strobe;
  logic              dft_commit_ack;
  logic              ex_sen;

  modport master (
    output data_in, dut_val_op, dut_commit_ack, dft_val_op, dft_commit_ack, ex_sen,
    input  data_out, dut_op_ack, dut_op_commit, dft_out, dft_op_ack, dft_op_commit,
           dft_output_strobe
  );

  modport slave (
    input  data_in, dut_val_op, dut_commit_ack, dft_val_op, dft_commit_ack, ex_sen,
    output data_out, dut_op_ack, dut_op_commit, dft_out, dft_op_ack, dft_op_commit,
           dft_output_strobe
  );
endinterface

// File: rtl/dut_op_responder.sv
// Accumulator test target: 4-phase op handshake drives a 32-bit accumulator core,
// a second handshake dumps {op_cnt, acc} as strobed words from a non-destructive shadow chain.
module dut_op_responder #(
  parameter int unsigned DATA_W    = 32,
  parameter int unsigned CHAIN_LEN = 64,
  parameter int unsigned DUMP_NBR  = 1
) (
  input  logic               clk,
  input  logic               reset,
  dut_op_responder_if.slave  bus
);

  localparam int unsigned WORDS = CHAIN_LEN / DATA_W;
  localparam int unsigned TOTAL = WORDS * DUMP_NBR;
  localparam int unsigned CNT_W = (TOTAL > 1) ? $clog2(TOTAL) : 1;

  typedef enum logic [2:0] {
    D_IDLE, D_ACK, D_EXEC, D_COMMIT, D_WAIT_REL
  } dut_state_t;

  typedef enum logic [2:0] {
    F_IDLE, F_ACK, F_SHIFT, F_COMMIT, F_WAIT_REL
  } dft_state_t;

  dut_state_t dut_state, dut_next;
  dft_state_t dft_state, dft_next;

  logic [31:0]          acc;
  logic [31:0]          op_cnt;
  logic [31:0]          operand;
  logic [31:0]          acc_sum;
  logic [DATA_W-1:0]    data_out_q;
  logic [DATA_W-1:0]    dft_out_q;
  logic [CHAIN_LEN-1:0] chain;
  logic [CHAIN_LEN-1:0] shadow;
  logic [CHAIN_LEN-1:0] shadow_rot;
  logic [CNT_W-1:0]     word_cnt;
  logic                 dut_accept;
  logic                 dft_accept;
  logic                 last_word;
  logic                 core_step;

  // The DUT request wins a same-cycle tie, so the DFT side also yields to a raw dut_val_op.
  always_comb begin
    dut_accept = (dut_state == D_IDLE) && bus.dut_val_op && (dft_state == F_IDLE);
    dft_accept = (dft_state == F_IDLE) && bus.dft_val_op && (dut_state == D_IDLE)
                 && !bus.dut_val_op;
    core_step  = (dut_state == D_EXEC) && !bus.ex_sen;
    acc_sum    = acc + operand;
    last_word  = (word_cnt == CNT_W'(TOTAL - 1));
  end

  // Rotating the shadow by one word per strobe returns it to its original image after
  // every full dump, so repeated dumps stay identical without re-reading the core.
  always_comb begin
    chain      = CHAIN_LEN'({op_cnt, acc});
    shadow_rot = (shadow >> DATA_W) | (shadow << (CHAIN_LEN - DATA_W));
  end

  always_comb begin
    dut_next = dut_state;
    case (dut_state)
      D_IDLE:     if (dut_accept)          dut_next = D_ACK;
      D_ACK:      if (!bus.dut_val_op)     dut_next = D_EXEC;
      D_EXEC:     if (!bus.ex_sen)         dut_next = D_COMMIT;
      D_COMMIT:   if (bus.dut_commit_ack)  dut_next = D_WAIT_REL;
      D_WAIT_REL: if (!bus.dut_commit_ack) dut_next = D_IDLE;
      default:                             dut_next = D_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      dut_state  <= D_IDLE;
      acc        <= '0;
      op_cnt     <= '0;
      operand    <= '0;
      data_out_q <= '0;
    end else begin
      dut_state <= dut_next;
      if (dut_accept) begin
        operand <= 32'(bus.data_in);
      end
      if (core_step) begin
        acc        <= acc_sum;
        op_cnt     <= op_cnt + 32'd1;
        data_out_q <= DATA_W'(acc_sum);
      end
    end
  end

  always_comb begin
    dft_next = dft_state;
    case (dft_state)
      F_IDLE:     if (dft_accept)          dft_next = F_ACK;
      F_ACK:      if (!bus.dft_val_op)     dft_next = F_SHIFT;
      F_SHIFT:    if (last_word)           dft_next = F_COMMIT;
      F_COMMIT:   if (bus.dft_commit_ack)  dft_next = F_WAIT_REL;
      F_WAIT_REL: if (!bus.dft_commit_ack) dft_next = F_IDLE;
      default:                             dft_next = F_IDLE;
    endcase
  end

  // dft_out is preloaded on the edge entering each SHIFT cycle so the strobe can be a
  // plain state decode and commit lands on the cycle after the final word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      dft_state <= F_IDLE;
      shadow    <= '0;
      dft_out_q <= '0;
      word_cnt  <= '0;
    end else begin
      dft_state <= dft_next;
      if ((dft_state == F_ACK) && !bus.dft_val_op) begin
        shadow    <= chain;
        dft_out_q <= chain[DATA_W-1:0];
        word_cnt  <= '0;
      end else if ((dft_state == F_SHIFT) && !last_word) begin
        shadow    <= shadow_rot;
        dft_out_q <= shadow_rot[DATA_W-1:0];
        word_cnt  <= word_cnt + CNT_W'(1);
      end
    end
  end

  assign bus.dut_op_ack        = (dut_state == D_ACK);
  assign bus.dut_op_commit     = (dut_state == D_COMMIT);
  assign bus.data_out          = data_out_q;
  assign bus.dft_op_ack        = (dft_state == F_ACK);
  assign bus.dft_op_commit     = (dft_state == F_COMMIT);
  assign bus.dft_output_strobe = (dft_state == F_SHIFT);
  assign bus.dft_out           = dft_out_q;

endmodule

// File: tb/tb_dut_op_responder.sv
// Directed + randomized bench for dut_op_responder against an arithmetic model of
// the accumulator and a word-list model of the scan dump.
`timescale 1ns/1ps
module tb_dut_op_responder;
  localparam int unsigned DW     = 32;
  localparam int unsigned CL     = 64;
  localparam int unsigned DN     = 2;
  localparam int unsigned CWORDS = CL / DW;
  localparam int unsigned NWORDS = CWORDS * DN;

  logic clk = 1'b0;
  logic reset = 1'b0;
  int   tests = 0;
  int   fails = 0;

  logic [31:0] m_acc = '0;
  logic [31:0] m_cnt = '0;

  always #5 clk = ~clk;

  dut_op_responder_if #(.DATA_W(DW)) bus ();

  dut_op_responder #(
    .DATA_W   (DW),
    .CHAIN_LEN(CL),
    .DUMP_NBR (DN)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
    tests++;
    assert (obs === want)
    else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, want);
    end
  endtask

  function automatic logic [31:0] chain_word(input int unsigned k);
    logic [63:0] ch;
    ch = {m_cnt, m_acc};
    return 32'(ch >> (DW * (k % CWORDS)));
  endfunction

  task automatic apply_reset();
    reset = 1'b0;
    repeat (2) step();
    m_acc = '0;
    m_cnt = '0;
    reset = 1'b1;
    step();
  endtask

  task automatic do_op(input logic [31:0] d, input int unsigned stall, input bit with_dft);
    bus.data_in    = d;
    bus.dut_val_op = 1'b1;
    if (with_dft) bus.dft_val_op = 1'b1;
    step();
    check("dut_ack", 32'(bus.dut_op_ack), 32'd1);
    if (with_dft) check("dft_yields", 32'(bus.dft_op_ack), 32'd0);
    repeat ($urandom_range(0, 2)) begin
      bus.data_in = $urandom;
      step();
      check("dut_ack_hold", 32'(bus.dut_op_ack), 32'd1);
    end
    bus.data_in    = $urandom;
    bus.dut_val_op = 1'b0;
    step();
    check("dut_ack_drop", 32'(bus.dut_op_ack), 32'd0);
    check("dut_early_commit", 32'(bus.dut_op_commit), 32'd0);
    bus.ex_sen = (stall != 0);
    repeat (stall) begin
      step();
      check("dut_stall", 32'(bus.dut_op_commit), 32'd0);
    end
    bus.ex_sen = 1'b0;
    step();
    m_acc = m_acc + d;
    m_cnt = m_cnt + 1;
    check("dut_commit", 32'(bus.dut_op_commit), 32'd1);
    check("data_out", bus.data_out, m_acc);
    if (with_dft) check("dft_still_waits", 32'(bus.dft_op_ack), 32'd0);
    repeat ($urandom_range(0, 2)) begin
      step();
      check("dut_commit_hold", 32'(bus.dut_op_commit), 32'd1);
    end
    bus.dut_commit_ack = 1'b1;
    step();
    check("dut_commit_drop", 32'(bus.dut_op_commit), 32'd0);
    check("data_out_hold", bus.data_out, m_acc);
    repeat ($urandom_range(0, 2)) begin
      step();
      check("dut_wait_rel", 32'(bus.dut_op_commit), 32'd0);
    end
    bus.dut_commit_ack = 1'b0;
    step();
    check("dut_idle", 32'(bus.dut_op_ack), 32'd0);
  endtask

  task automatic do_dump(input bit poke);
    logic [31:0] got[$];
    bus.dft_val_op = 1'b1;
    bus.ex_sen     = 1'($urandom_range(0, 1));
    step();
    check("dft_ack", 32'(bus.dft_op_ack), 32'd1);
    check("dft_no_strobe", 32'(bus.dft_output_strobe), 32'd0);
    if (poke) begin
      bus.dut_val_op = 1'b1;
      step();
      check("dut_blocked", 32'(bus.dut_op_ack), 32'd0);
      bus.dut_val_op = 1'b0;
    end
    repeat ($urandom_range(0, 1)) begin
      step();
      check("dft_ack_hold", 32'(bus.dft_op_ack), 32'd1);
    end
    bus.dft_val_op = 1'b0;
    step();
    for (int i = 0; i < int'(NWORDS) + 4 && bus.dft_output_strobe; i++) begin
      got.push_back(bus.dft_out);
      step();
    end
    check("dump_len", 32'(got.size()), 32'(NWORDS));
    foreach (got[k]) check("dump_word", got[k], chain_word(k));
    check("dft_commit", 32'(bus.dft_op_commit), 32'd1);
    check("dft_strobe_off", 32'(bus.dft_output_strobe), 32'd0);
    check("dft_out_hold", bus.dft_out, chain_word(NWORDS - 1));
    check("dut_untouched", 32'(bus.dut_op_ack), 32'd0);
    repeat ($urandom_range(0, 2)) begin
      step();
      check("dft_commit_hold", 32'(bus.dft_op_commit), 32'd1);
    end
    bus.dft_commit_ack = 1'b1;
    step();
    check("dft_commit_drop", 32'(bus.dft_op_commit), 32'd0);
    bus.dft_commit_ack = 1'b0;
    step();
    check("dft_idle", 32'(bus.dft_op_ack), 32'd0);
    bus.ex_sen = 1'b0;
  endtask

  initial begin
    bus.data_in        = '0;
    bus.dut_val_op     = 1'b0;
    bus.dut_commit_ack = 1'b0;
    bus.dft_val_op     = 1'b0;
    bus.dft_commit_ack = 1'b0;
    bus.ex_sen         = 1'b0;
    reset              = 1'b0;
    repeat (3) step();
    check("rst_dut_ack", 32'(bus.dut_op_ack), 32'd0);
    check("rst_dut_commit", 32'(bus.dut_op_commit), 32'd0);
    check("rst_data_out", bus.data_out, 32'd0);
    check("rst_dft_ack", 32'(bus.dft_op_ack), 32'd0);
    check("rst_dft_commit", 32'(bus.dft_op_commit), 32'd0);
    check("rst_strobe", 32'(bus.dft_output_strobe), 32'd0);
    check("rst_dft_out", bus.dft_out, 32'd0);
    reset = 1'b1;
    step();

    do_op(32'd5, 0, 1'b0);
    do_op(32'd7, 0, 1'b0);

    apply_reset();
    do_op(32'd1, 0, 1'b0);
    do_op(32'hFFFF_FFFF, 0, 1'b0);
    do_dump(1'b0);

    apply_reset();
    do_op(32'h12, 0, 1'b0);
    do_op(32'h0, 0, 1'b0);
    do_op(32'h0, 0, 1'b0);
    do_dump(1'b1);

    do_op($urandom, 0, 1'b1);
    do_dump(1'b0);

    do_op($urandom, 5, 1'b0);

    for (int n = 0; n < 12; n++) begin
      if ($urandom_range(0, 2) == 0) do_dump(1'($urandom_range(0, 1)));
      else do_op($urandom, $urandom_range(0, 3), 1'b0);
    end
    do_dump(1'b0);

    bus.dft_val_op = 1'b1;
    step();
    check("mid_ack", 32'(bus.dft_op_ack), 32'd1);
    bus.dft_val_op = 1'b0;
    step();
    check("mid_first_strobe", 32'(bus.dft_output_strobe), 32'd1);
    check("mid_first_word", bus.dft_out, chain_word(0));
    reset = 1'b0;
    step();
    check("mid_rst_strobe", 32'(bus.dft_output_strobe), 32'd0);
    check("mid_rst_dft_out", bus.dft_out, 32'd0);
    check("mid_rst_commit", 32'(bus.dft_op_commit), 32'd0);
    check("mid_rst_data_out", bus.data_out, 32'd0);
    reset = 1'b1;
    m_acc = '0;
    m_cnt = '0;
    repeat (4) begin
      step();
      check("post_rst_strobe", 32'(bus.dft_output_strobe), 32'd0);
      check("post_rst_commit", 32'(bus.dft_op_commit), 32'd0);
    end
    do_dump(1'b0);
    do_op(32'd9, 0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/dut_op_responder.md
Name: dut_op_responder

Overview:
- DUT/DFT-side responder for the prewrapper handshake interface.
- Receives operations on the dut_* 4-phase handshake and runs a 32-bit accumulator core.
- Answers scan-dump requests on the dft_* handshake by shifting core state out as strobed 32-bit words.
- Sits under the prewrapper as the reusable test target for wrapper bring-up and regression.

Parameters:
- DATA_W, 32, width of data_in, data_out and dft_out.
- CHAIN_LEN, 64, scan chain length in bits; must be a multiple of DATA_W.
- DUMP_NBR, 1, number of full chain dumps per DFT operation, range 1..15.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-low reset.
- data_in  input  DATA_W  operand; sampled only at the val_op accept edge.
- data_out  output  DATA_W  result; valid while dut_op_commit=1.
- dut_val_op  input  1  operation request from the initiator.
- dut_op_ack  output  1  request accepted.
- dut_op_commit  output  1  result ready.
- dut_commit_ack  input  1  initiator has consumed the result.
- dft_out  output  DATA_W  scan dump word.
- dft_val_op  input  1  dump request.
- dft_op_ack  output  1  dump request accepted.
- dft_op_commit  output  1  dump complete.
- dft_output_strobe  output  1  one-cycle qualifier for each dft_out word.
- dft_commit_ack  input  1  initiator has seen dump completion.
- ex_sen  input  1  external scan enable; freezes core state.

Behaviour:
- Reset (reset=0 at a clock edge):
  - All outputs are 0.
  - acc=0 and op_cnt=0.
  - Both FSMs go to IDLE.
  - This applies mid-operation too: no partial dump or commit completes afterwards.
- Core state is {op_cnt[31:0], acc[31:0]} (LSB = acc[0]). Bits above 64 are zero when CHAIN_LEN > 64.
- DUT FSM states: IDLE, ACK, EXEC, COMMIT, WAIT_REL.
  - IDLE: dut_val_op=1 and DFT FSM idle → latch data_in, set dut_op_ack=1, go to ACK. If both requests rise in the same cycle, DUT wins and the DFT FSM waits.
  - ACK: hold ack until dut_val_op=0; then ack=0, go to EXEC.
  - EXEC: if ex_sen=0, acc <= acc + operand (mod 2^32) and op_cnt <= op_cnt+1; go to COMMIT. If ex_sen=1, stall in EXEC.
  - COMMIT: data_out = updated acc; dut_op_commit=1 until dut_commit_ack=1. Then commit=0 and data_out holds, go to WAIT_REL.
  - WAIT_REL: go to IDLE when dut_commit_ack=0.
  - Latency: commit asserts 2 cycles after val_op falls when ex_sen=0.
- DFT FSM states: IDLE, ACK, SHIFT, COMMIT, WAIT_REL.
  - Accepts only while the DUT FSM is IDLE.
  - ACK/release behaves like the DUT FSM.
  - SHIFT emits CHAIN_LEN/DATA_W words per dump, DUMP_NBR dumps in total.
  - Word k = chain bits [k*DATA_W +: DATA_W]; one word per cycle, each with dft_output_strobe=1.
  - The chain is non-destructive: a shadow copy is captured on entry to SHIFT, so every dump is identical.
  - After the last word, strobe=0 and dft_op_commit=1 on the next cycle; it holds until dft_commit_ack.
  - WAIT_REL waits for dft_commit_ack=0.
  - dft_out holds its last word when strobe=0.
- ex_sen=1 blocks acc/op_cnt updates only; handshakes and dumps continue.
- Protocol violations:
  - val_op dropping before ack: ignored in IDLE.
  - Request held through IDLE re-entry: it is treated as a new request.

Test Plan:
- Reset, then val_op with data_in=5, full handshake → ack, then commit with data_out=5; repeat with 7 → data_out=12.
- data_in=0xFFFFFFFF after acc=1 → data_out=0 (wraparound); op_cnt increments.
- acc=0x12, op_cnt=3, DUMP_NBR=2, CHAIN_LEN=64 → exactly 4 strobes with words 0x12, 3, 0x12, 3, then dft_op_commit.
- dut_val_op and dft_val_op rise in the same cycle → DUT completes first; dump shows the post-op state.
- ex_sen=1 during EXEC for 5 cycles → commit is delayed 5 cycles and the result is correct.
- Reset low mid-SHIFT after 1 word → no further strobes, outputs 0; a new dump returns acc=0, op_cnt=0.
